// File: rtl/vram_arbiter_pkg.sv
// Shared constants, state encoding and display-window helper for the VRAM arbiter.
package vram_arbiter_pkg;

    // Frame-RAM geometry: one word per 4x4-pixel block.
    localparam int VRAM_COLS  = 200;
    localparam int VRAM_ROWS  = 150;
    localparam int VRAM_DEPTH = VRAM_COLS * VRAM_ROWS;
    localparam int ADDR_W     = 15;

    // Visible window in timing-generator counts.
    localparam logic [10:0] VC_FIRST = 11'd28;
    localparam logic [10:0] VC_LAST  = 11'd626;
    localparam logic [10:0] HC_FIRST = 11'd214;
    localparam logic [10:0] HC_LAST  = 11'd1010;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    // True on the first pixel of each visible 4-pixel block: the cycle the
    // display owns the RAM port.
    function automatic logic is_disp_slot(input logic [10:0] hc, input logic [10:0] vc);
        return (vc >= VC_FIRST) && (vc <= VC_LAST) &&
               (hc >= HC_FIRST) && (hc <= HC_LAST) &&
               (((hc - HC_FIRST) & 11'd3) == 11'd0);
    endfunction

endpackage

// File: rtl/vram_arbiter_addr_calc.sv
// Block (row, col) to frame-RAM address: row*200 + col using shifts and adds only.
// Out-of-range coordinates wrap silently; callers drop those writes.
module vram_addr_calc
    import vram_arbiter_pkg::*;
(
    input  logic [7:0]        row_i,
    input  logic [7:0]        col_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] row_s;
    logic [ADDR_W-1:0] col_s;

    assign row_s  = {7'd0, row_i};
    assign col_s  = {7'd0, col_i};
    // 200 = 128 + 64 + 8
    assign addr_o = (row_s << 7) + (row_s << 6) + (row_s << 3) + col_s;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-RAM arbiter: display reads have absolute priority, then the
// clear-screen fill, then draw writes. Display data returns one cycle after the
// read slot and is held in a pixel register for the rest of the 4-pixel block.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int COLS  = VRAM_COLS,
    parameter int ROWS  = VRAM_ROWS,
    parameter int DEPTH = VRAM_DEPTH
)
(
    input  logic        clk,
    input  logic        clr,
    input  logic [10:0] hc_i,
    input  logic [10:0] vc_i,
    input  logic        vidon_i,
    input  logic        wr_req_i,
    input  logic [7:0]  wr_x_i,
    input  logic [7:0]  wr_y_i,
    input  logic [7:0]  wr_color_i,
    output logic        wr_ack_o,
    input  logic        clear_req_i,
    input  logic [7:0]  clear_color_i,
    output logic        busy_o,
    output logic [14:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    output logic [7:0]  rgb_o
);

    arb_state_e        state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              busy_q;
    logic              disp_q;
    logic [7:0]        pix_q;

    logic              disp_slot_s;
    logic [7:0]        disp_row_s;
    logic [7:0]        disp_col_s;
    logic [ADDR_W-1:0] disp_addr_s;
    logic [ADDR_W-1:0] draw_addr_s;
    logic              draw_in_range_s;
    logic              clr_last_s;

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [7:0]        mem_wdata_s;
    logic              wr_ack_s;

    assign disp_slot_s     = is_disp_slot(hc_i, vc_i);
    assign disp_row_s      = 8'((vc_i - VC_FIRST) >> 2);
    assign disp_col_s      = 8'((hc_i - HC_FIRST) >> 2);
    assign draw_in_range_s = ({24'd0, wr_x_i} < 32'(COLS)) && ({24'd0, wr_y_i} < 32'(ROWS));
    assign clr_last_s      = (clr_cnt_q == ADDR_W'(DEPTH - 1));

    vram_addr_calc u_disp_addr (
        .row_i  (disp_row_s),
        .col_i  (disp_col_s),
        .addr_o (disp_addr_s)
    );

    vram_addr_calc u_draw_addr (
        .row_i  (wr_y_i),
        .col_i  (wr_x_i),
        .addr_o (draw_addr_s)
    );

    // Arbiter FSM: start a fill on clear_req from IDLE, step the fill counter on
    // every cycle the display does not own, return to IDLE after the last word.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= {ADDR_W{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_req_i) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= {ADDR_W{1'b0}};
                        busy_q    <= 1'b1;
                    end else begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (disp_slot_s) begin
                        state_q   <= ST_CLEAR;
                    end else if (clr_last_s) begin
                        state_q   <= ST_IDLE;
                        clr_cnt_q <= {ADDR_W{1'b0}};
                        busy_q    <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    clr_cnt_q <= {ADDR_W{1'b0}};
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Display pipeline: remember a read slot, then latch the returned block colour.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            disp_q <= 1'b0;
            pix_q  <= 8'h00;
        end else begin
            disp_q <= disp_slot_s;
            if (disp_q) begin
                pix_q <= mem_rdata_i;
            end else begin
                pix_q <= pix_q;
            end
        end
    end

    // RAM port mux in priority order: display read, clear fill, draw write.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = 8'h00;
        wr_ack_s    = 1'b0;
        if (clr) begin
            mem_we_s = 1'b0;
        end else if (disp_slot_s) begin
            mem_addr_s = disp_addr_s;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_cnt_q;
            mem_wdata_s = clear_color_i;
        end else if (wr_req_i) begin
            // Out-of-range writes are acknowledged so the requester moves on,
            // but never reach the RAM.
            wr_ack_s = 1'b1;
            if (draw_in_range_s) begin
                mem_we_s    = 1'b1;
                mem_addr_s  = draw_addr_s;
                mem_wdata_s = wr_color_i;
            end else begin
                mem_we_s    = 1'b0;
            end
        end else begin
            mem_we_s = 1'b0;
        end
    end

    assign mem_we_o    = mem_we_s;
    assign mem_addr_o  = mem_addr_s;
    assign mem_wdata_o = mem_wdata_s;
    assign wr_ack_o    = wr_ack_s;
    assign busy_o      = busy_q;
    assign rgb_o       = vidon_i ? pix_q : 8'h00;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter with an external RAM and a frame-level model.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic [10:0] hc, vc;
    logic        vidon, wr_req, wr_ack, clear_req, busy, mem_we;
    logic [7:0]  wr_x, wr_y, wr_color, clear_color, mem_wdata, mem_rdata, rgb;
    logic [14:0] mem_addr;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .clr(clr), .hc_i(hc), .vc_i(vc), .vidon_i(vidon),
        .wr_req_i(wr_req), .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_color_i(wr_color),
        .wr_ack_o(wr_ack), .clear_req_i(clear_req), .clear_color_i(clear_color),
        .busy_o(busy), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .rgb_o(rgb)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] ram  [0:32767];
    logic [7:0] gold [0:29999];

    // reference model state
    bit         m_clearing;
    int         m_idx;
    logic [7:0] m_pix;
    bit         m_pend;
    logic [7:0] m_pend_val;
    bit         m_last_ack;
    logic [7:0] rdata_next;

    // stimulus control
    int cur_h, cur_v, line_no;
    bit rand_mode, noise, force_clear;
    int clr_pulses;
    int vtab[5] = '{27, 28, 626, 627, 100};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s hc=%0d vc=%0d got=%0h exp=%0h", tag, hc, vc, got, exp);
        end
    endtask

    // Compare this cycle against the model, then advance model and RAM by one edge.
    task automatic eval();
        int  h, v, e_addr;
        bit  disp, e_we, e_ack, e_busy;
        logic [7:0] e_wd, e_rgb;
        h = int'(hc); v = int'(vc);
        disp   = (v >= 28) && (v <= 626) && (h >= 214) && (h <= 1010) && (((h - 214) % 4) == 0);
        e_addr = 0; e_we = 0; e_ack = 0; e_wd = 8'h00;
        if (clr) begin
            m_clearing = 0; m_idx = 0; m_pix = 8'h00; m_pend = 0;
            e_busy = 0; e_rgb = 8'h00;
        end else begin
            e_busy = m_clearing;
            e_rgb  = vidon ? m_pix : 8'h00;
            if (disp) begin
                e_addr = ((v - 28) / 4) * 200 + (h - 214) / 4;
            end else if (m_clearing) begin
                e_we = 1; e_addr = m_idx; e_wd = clear_color;
            end else if (wr_req) begin
                e_ack = 1;
                if (wr_x < 8'd200 && wr_y < 8'd150) begin
                    e_we = 1; e_addr = int'(wr_y) * 200 + int'(wr_x); e_wd = wr_color;
                end
            end
        end
        chk_eq("wr_ack",    32'(wr_ack),    32'(e_ack));
        chk_eq("mem_we",    32'(mem_we),    32'(e_we));
        chk_eq("mem_addr",  32'(mem_addr),  32'(e_addr));
        chk_eq("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        chk_eq("busy",      32'(busy),      32'(e_busy));
        chk_eq("rgb",       32'(rgb),       32'(e_rgb));
        if (e_busy && mem_we) clr_pulses++;
        // external synchronous RAM driven by the DUT
        rdata_next = ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
        if (!clr) begin
            if (e_we) gold[e_addr] = e_wd;
            if (m_pend) m_pix = m_pend_val;
            m_pend = disp;
            if (disp) m_pend_val = gold[e_addr];
            if (!m_clearing) begin
                if (clear_req) begin m_clearing = 1; m_idx = 0; end
            end else if (!disp) begin
                if (m_idx == 29999) m_clearing = 0;
                else m_idx++;
            end
        end
        m_last_ack = e_ack;
    endtask

    task automatic cyc();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
        mem_rdata = rdata_next;
    endtask

    task automatic new_req();
        wr_req   = 1'b1;
        wr_x     = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 199));
        wr_y     = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 149));
        wr_color = 8'($urandom);
    endtask

    // One cycle of free-running scan with a random, protocol-obeying requester.
    task automatic adv();
        hc = 11'(cur_h);
        vc = 11'(cur_v);
        if (rand_mode) begin
            vidon = ($urandom_range(0, 7) != 0);
            if (wr_req && m_last_ack) begin
                if ($urandom_range(0, 1) == 1) new_req();
                else wr_req = 1'b0;
            end else if (wr_req) begin
                if ($urandom_range(0, 63) == 0) wr_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                new_req();
            end
        end
        clear_req = force_clear | (noise && m_clearing && ($urandom_range(0, 499) == 0));
        cyc();
        cur_h++;
        if (cur_h == 1040) begin
            cur_h = 0;
            line_no++;
            cur_v = (line_no < 5) ? vtab[line_no] : $urandom_range(20, 640);
        end
    endtask

    initial begin
        clr = 1'b1; hc = 11'd0; vc = 11'd0; vidon = 1'b1; wr_req = 1'b0;
        wr_x = 8'd0; wr_y = 8'd0; wr_color = 8'd0; clear_req = 1'b0;
        clear_color = 8'd0; mem_rdata = 8'd0;
        for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
        for (int i = 0; i < 30000; i++) begin
            gold[i] = 8'($urandom);
            ram[i]  = gold[i];
        end
        gold[0] = 8'hE0; ram[0] = 8'hE0;
        m_clearing = 0; m_idx = 0; m_pix = 8'h00; m_pend = 0; m_pend_val = 8'h00;
        m_last_ack = 0; rdata_next = 8'h00;
        rand_mode = 0; noise = 0; force_clear = 0; clr_pulses = 0;
        @(posedge clk); #1;

        // reset: request present, outputs must stay quiet
        wr_req = 1'b1; wr_x = 8'd1; wr_y = 8'd1;
        #2 chk_eq("rst_ack", 32'(wr_ack), 32'd0);
        chk_eq("rst_we", 32'(mem_we), 32'd0);
        cyc();
        wr_req = 1'b0; clr = 1'b0;
        cyc();

        // display read of block 0 and its hold window
        vc = 11'd28;
        for (int h = 214; h <= 219; h++) begin
            hc = 11'(h);
            #2;
            if (h == 214) begin
                chk_eq("disp_addr0", 32'(mem_addr), 32'd0);
                chk_eq("disp_we0",   32'(mem_we),   32'd0);
            end
            if (h >= 217) chk_eq("disp_rgb_e0", 32'(rgb), 32'hE0);
            cyc();
        end

        // write colliding with a display slot
        vc = 11'd100; hc = 11'd217; cyc();
        hc = 11'd218; wr_req = 1'b1; wr_x = 8'd5; wr_y = 8'd3; wr_color = 8'h1C;
        #2 chk_eq("coll_ack_slot", 32'(wr_ack), 32'd0);
        cyc();
        hc = 11'd219;
        #2 chk_eq("coll_ack", 32'(wr_ack), 32'd1);
        chk_eq("coll_addr", 32'(mem_addr), 32'd605);
        chk_eq("coll_we",   32'(mem_we),   32'd1);
        cyc();
        wr_req = 1'b0;

        // out-of-range draw in blanking
        vc = 11'd0; hc = 11'd5; wr_req = 1'b1; wr_x = 8'd200; wr_y = 8'd0;
        #2 chk_eq("oor_ack", 32'(wr_ack), 32'd1);
        chk_eq("oor_we", 32'(mem_we), 32'd0);
        cyc();
        wr_req = 1'b0; hc = 11'd6;
        #2 chk_eq("oor_ack_off", 32'(wr_ack), 32'd0);
        cyc();

        // random scan, including window-edge lines
        rand_mode = 1; cur_h = 0; line_no = 0; cur_v = vtab[0];
        for (int n = 0; n < 6 * 1040; n++) adv();

        // clear_req together with a draw write, then a blocked request
        rand_mode = 0; vidon = 1'b1; clr_pulses = 0;
        vc = 11'd0; hc = 11'd10; clear_req = 1'b1; clear_color = 8'h03;
        wr_req = 1'b1; wr_x = 8'd7; wr_y = 8'd2; wr_color = 8'h5A;
        #2 chk_eq("clrwr_ack", 32'(wr_ack), 32'd1);
        chk_eq("clrwr_addr", 32'(mem_addr), 32'd407);
        cyc();
        clear_req = 1'b0; hc = 11'd11; wr_x = 8'd9; wr_y = 8'd9;
        #2 chk_eq("clr_busy", 32'(busy), 32'd1);
        chk_eq("clr_first_addr", 32'(mem_addr), 32'd0);
        chk_eq("clr_block_ack", 32'(wr_ack), 32'd0);
        cyc();

        // full fill with ignored clear_req pulses and a held requester
        rand_mode = 1; noise = 1; cur_h = 12; cur_v = 0;
        for (int n = 0; n < 60000 && m_clearing; n++) adv();
        noise = 0;
        #2 chk_eq("clear_pulses", 32'(clr_pulses), 32'd30000);
        chk_eq("clear_busy_end", 32'(busy), 32'd0);
        for (int n = 0; n < 1500; n++) adv();

        // reset in the middle of a fill, then restart from address 0
        clear_color = 8'($urandom);
        force_clear = 1; adv(); force_clear = 0;
        for (int n = 0; n < 5000 && m_idx < 1000; n++) adv();
        clr = 1'b1; adv();
        clr = 1'b0; adv();
        clear_color = 8'($urandom);
        force_clear = 1; adv(); force_clear = 0;
        for (int n = 0; n < 2000; n++) adv();
        clr = 1'b1; adv();
        clr = 1'b0;
        for (int n = 0; n < 2000; n++) adv();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
